// File: rtl/bmp180_pkg.sv
// Shared definitions for the BMP180 command sequencer.
// Holds the command byte values, sensor register addresses, error codes,
// the state encoding and the command-byte decode function.
package bmp180_pkg;

  // Command bytes stored in the command ROM
  localparam logic [7:0] CMD_CALIB    = 8'hAA;
  localparam logic [7:0] CMD_CHIP_ID  = 8'hD0;
  localparam logic [7:0] CMD_SOFT_RST = 8'hB6;
  localparam logic [7:0] CMD_TEMP     = 8'h2E;
  localparam logic [7:0] CMD_P_OSS0   = 8'h34;
  localparam logic [7:0] CMD_P_OSS1   = 8'h74;
  localparam logic [7:0] CMD_P_OSS2   = 8'hB4;
  localparam logic [7:0] CMD_P_OSS3   = 8'hF4;

  // BMP180 register addresses
  localparam logic [7:0] REG_CTRL_MEAS  = 8'hF4;
  localparam logic [7:0] REG_OUT_MSB    = 8'hF6;
  localparam logic [7:0] REG_SOFT_RESET = 8'hE0;
  localparam logic [7:0] REG_CALIB      = 8'hAA;
  localparam logic [7:0] REG_CHIP_ID    = 8'hD0;

  // Conversion counter width: covers 25.5 ms at 50 MHz
  localparam int unsigned CNT_W = 21;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_CMD  = 2'b01,
    ERR_NACK = 2'b10,
    ERR_ADDR = 2'b11
  } err_e;

  // Sequencer state encoding
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_FETCH   = 4'd1;
  localparam logic [3:0] ST_CHECK   = 4'd2;
  localparam logic [3:0] ST_WR_REQ  = 4'd3;
  localparam logic [3:0] ST_WR_WAIT = 4'd4;
  localparam logic [3:0] ST_CONV    = 4'd5;
  localparam logic [3:0] ST_RD_REQ  = 4'd6;
  localparam logic [3:0] ST_RD_WAIT = 4'd7;
  localparam logic [3:0] ST_FIN     = 4'd8;

  // First transaction of a command. For measurement commands the first
  // transaction is the control write; has_read then requests the result
  // read from REG_OUT_MSB after conv_n/10 ms, with nbytes bytes.
  typedef struct packed {
    logic       valid;
    logic       rw;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic [4:0] nbytes;
    logic [7:0] conv_n;
    logic       has_read;
  } cmd_dec_t;

  function automatic cmd_dec_t cmd_decode(input logic [7:0] cmd);
    cmd_dec_t d;
    d = '0;
    d.valid = 1'b1;
    case (cmd)
      CMD_CALIB: begin
        d.rw = 1'b1; d.reg_addr = REG_CALIB; d.nbytes = 5'd22;
      end
      CMD_CHIP_ID: begin
        d.rw = 1'b1; d.reg_addr = REG_CHIP_ID; d.nbytes = 5'd1;
      end
      CMD_SOFT_RST: begin
        d.reg_addr = REG_SOFT_RESET; d.wdata = CMD_SOFT_RST;
      end
      CMD_TEMP, CMD_P_OSS0, CMD_P_OSS1, CMD_P_OSS2, CMD_P_OSS3: begin
        d.reg_addr = REG_CTRL_MEAS;
        d.wdata    = cmd;
        d.has_read = 1'b1;
        d.nbytes   = (cmd == CMD_TEMP) ? 5'd2 : 5'd3;
        case (cmd)
          CMD_P_OSS1: d.conv_n = 8'd75;
          CMD_P_OSS2: d.conv_n = 8'd135;
          CMD_P_OSS3: d.conv_n = 8'd255;
          default:    d.conv_n = 8'd45;
        endcase
      end
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bmp180_cmd_seq_if.sv
// I2C transaction request channel between the command sequencer (master)
// and the I2C byte-level master (slave).
//   i2c_req/i2c_ack   : request held until acknowledged
//   i2c_rw/reg/wdata/nbytes : transaction fields, stable while i2c_req = 1
//   i2c_done/i2c_nack : one-cycle completion pulse, nack qualifies done
interface bmp180_cmd_seq_if;
  import bmp180_pkg::*;

  logic       i2c_req;
  logic       i2c_ack;
  logic       i2c_rw;
  logic [7:0] i2c_reg;
  logic [7:0] i2c_wdata;
  logic [4:0] i2c_nbytes;
  logic       i2c_done;
  logic       i2c_nack;

  modport master (
    output i2c_req, i2c_rw, i2c_reg, i2c_wdata, i2c_nbytes,
    input  i2c_ack, i2c_done, i2c_nack
  );

  modport slave (
    input  i2c_req, i2c_rw, i2c_reg, i2c_wdata, i2c_nbytes,
    output i2c_ack, i2c_done, i2c_nack
  );

endinterface

// File: rtl/bmp180_conv_timer.sv
// Conversion wait down-counter.
//   load_i/load_val_i : load the count (priority over decrement)
//   dec_i             : decrement by one, saturating at zero
//   zero_o            : count is zero
module bmp180_conv_timer
  import bmp180_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bmp180_cmd_seq.sv
// BMP180 command sequencer.
// Fetches one command byte from the command ROM, decodes it into one or two
// I2C register transactions (with a conversion wait for measurements) and
// reports completion with an error code.
//   CLK, RST_n            : clock, asynchronous active-low reset
//   I_START, I_CMD_ADDR   : start pulse and ROM address of the command
//   O_ADDR_ROM, I_ADDR_ROM, I_DATA_ROM : command ROM port (1-cycle latency)
//   i2c                   : I2C request channel (master side)
//   O_BUSY, O_DONE, O_ERR : status; O_ERR valid with O_DONE, held until next start
module bmp180_cmd_seq
  import bmp180_pkg::*;
#(
  parameter int unsigned ADDR_ROM_SZ = 4,
  parameter int unsigned DATA_ROM_SZ = 8,
  parameter int unsigned CLK_KHZ     = 50000
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic                   I_START,
  input  logic [ADDR_ROM_SZ-1:0] I_CMD_ADDR,
  output logic [ADDR_ROM_SZ-1:0] O_ADDR_ROM,
  input  logic [ADDR_ROM_SZ-1:0] I_ADDR_ROM,
  input  logic [DATA_ROM_SZ-1:0] I_DATA_ROM,
  bmp180_cmd_seq_if.master       i2c,
  output logic                   O_BUSY,
  output logic                   O_DONE,
  output logic [1:0]             O_ERR
);

  // Timer is loaded with wait-1 and CONV exits on zero, so CONV spans
  // exactly CLK_KHZ*N/10 cycles.
  localparam logic [CNT_W-1:0] LD_45  = CNT_W'(CLK_KHZ * 45 / 10 - 1);
  localparam logic [CNT_W-1:0] LD_75  = CNT_W'(CLK_KHZ * 75 / 10 - 1);
  localparam logic [CNT_W-1:0] LD_135 = CNT_W'(CLK_KHZ * 135 / 10 - 1);
  localparam logic [CNT_W-1:0] LD_255 = CNT_W'(CLK_KHZ * 255 / 10 - 1);

  logic [3:0]             state_q, state_d;
  logic [ADDR_ROM_SZ-1:0] addr_q, addr_d;
  logic                   req_q, req_d;
  logic                   rw_q, rw_d;
  logic [7:0]             reg_q, reg_d;
  logic [7:0]             wdata_q, wdata_d;
  logic [4:0]             nbytes_q, nbytes_d;
  logic                   has_read_q, has_read_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  err_e                   err_q, err_d;

  cmd_dec_t         dec;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;

  always_comb begin
    dec = cmd_decode(I_DATA_ROM[7:0]);
    case (dec.conv_n)
      8'd45:   tmr_val = LD_45;
      8'd75:   tmr_val = LD_75;
      8'd135:  tmr_val = LD_135;
      8'd255:  tmr_val = LD_255;
      default: tmr_val = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    nbytes_d   = nbytes_q;
    has_read_d = has_read_q;
    err_d      = err_q;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (I_START) begin
          addr_d  = I_CMD_ADDR;
          err_d   = ERR_NONE;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_CHECK;
      ST_CHECK: begin
        if (I_ADDR_ROM != addr_q) begin
          err_d   = ERR_ADDR;
          state_d = ST_FIN;
        end else if (!dec.valid) begin
          err_d   = ERR_CMD;
          state_d = ST_FIN;
        end else begin
          rw_d       = dec.rw;
          reg_d      = dec.reg_addr;
          wdata_d    = dec.wdata;
          nbytes_d   = dec.nbytes;
          has_read_d = dec.has_read;
          // Loaded here and held until CONV starts counting
          tmr_load   = 1'b1;
          state_d    = dec.rw ? ST_RD_REQ : ST_WR_REQ;
        end
      end
      ST_WR_REQ: if (i2c.i2c_ack) state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (i2c.i2c_done) begin
          if (i2c.i2c_nack) begin
            err_d   = ERR_NACK;
            state_d = ST_FIN;
          end else if (has_read_q) begin
            rw_d    = 1'b1;
            reg_d   = REG_OUT_MSB;
            state_d = ST_CONV;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_CONV: begin
        tmr_dec = 1'b1;
        if (tmr_zero) state_d = ST_RD_REQ;
      end
      ST_RD_REQ: if (i2c.i2c_ack) state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (i2c.i2c_done) begin
          if (i2c.i2c_nack) err_d = ERR_NACK;
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are derived from the next state
    req_d  = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      req_q      <= 1'b0;
      rw_q       <= 1'b0;
      reg_q      <= '0;
      wdata_q    <= '0;
      nbytes_q   <= '0;
      has_read_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      rw_q       <= rw_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      nbytes_q   <= nbytes_d;
      has_read_q <= has_read_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  bmp180_conv_timer u_conv_timer (
    .clk        (CLK),
    .rst_n      (RST_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  assign O_ADDR_ROM     = addr_q;
  assign i2c.i2c_req    = req_q;
  assign i2c.i2c_rw     = rw_q;
  assign i2c.i2c_reg    = reg_q;
  assign i2c.i2c_wdata  = wdata_q;
  assign i2c.i2c_nbytes = nbytes_q;
  assign O_BUSY         = busy_q;
  assign O_DONE         = done_q;
  assign O_ERR          = err_q;

endmodule

// File: tb/tb_bmp180_cmd_seq.sv
module tb_bmp180_cmd_seq;

  localparam int unsigned KHZ = 10;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       I_START = 1'b0;
  logic [3:0] I_CMD_ADDR = '0;
  logic [3:0] O_ADDR_ROM;
  logic [3:0] rom_echo;
  logic [7:0] rom_data;
  logic       O_BUSY, O_DONE;
  logic [1:0] O_ERR;
  logic       bad_echo = 1'b0;
  logic [7:0] rom [16];

  bmp180_cmd_seq_if i2c ();

  bmp180_cmd_seq #(.ADDR_ROM_SZ(4), .DATA_ROM_SZ(8), .CLK_KHZ(KHZ)) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .I_START    (I_START),
    .I_CMD_ADDR (I_CMD_ADDR),
    .O_ADDR_ROM (O_ADDR_ROM),
    .I_ADDR_ROM (rom_echo),
    .I_DATA_ROM (rom_data),
    .i2c        (i2c),
    .O_BUSY     (O_BUSY),
    .O_DONE     (O_DONE),
    .O_ERR      (O_ERR)
  );

  always #5 CLK = ~CLK;

  // Registered command ROM with address echo
  always @(posedge CLK) begin
    rom_data <= rom[O_ADDR_ROM];
    rom_echo <= bad_echo ? (O_ADDR_ROM ^ 4'd1) : O_ADDR_ROM;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit         rw;
    logic [7:0] rg;
    logic [7:0] wd;
    int         nb;
  } txn_t;

  txn_t exp_q[$];
  txn_t got_q[$];
  int   exp_err;
  int   exp_wait;

  // Reference: what the host should see for a command byte
  task automatic expect_cmd(input logic [7:0] b, input bit nw, input bit nr);
    txn_t t;
    exp_q.delete();
    exp_err  = 0;
    exp_wait = 0;
    case (b)
      8'hAA: begin t = '{1, 8'hAA, 8'h00, 22}; exp_q.push_back(t); if (nr) exp_err = 2; end
      8'hD0: begin t = '{1, 8'hD0, 8'h00, 1};  exp_q.push_back(t); if (nr) exp_err = 2; end
      8'hB6: begin t = '{0, 8'hE0, 8'hB6, 0};  exp_q.push_back(t); if (nw) exp_err = 2; end
      8'h2E, 8'h34, 8'h74, 8'hB4, 8'hF4: begin
        case (b)
          8'h74:   exp_wait = KHZ * 75 / 10;
          8'hB4:   exp_wait = KHZ * 135 / 10;
          8'hF4:   exp_wait = KHZ * 255 / 10;
          default: exp_wait = KHZ * 45 / 10;
        endcase
        t = '{0, 8'hF4, b, 0};
        exp_q.push_back(t);
        if (nw) exp_err = 2;
        else begin
          t = '{1, 8'hF6, 8'h00, (b == 8'h2E) ? 2 : 3};
          exp_q.push_back(t);
          if (nr) exp_err = 2;
        end
      end
      default: exp_err = 1;
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},   O_ADDR_ROM, 0);
    check({tag, "_req"},    i2c.i2c_req, 0);
    check({tag, "_rw"},     i2c.i2c_rw, 0);
    check({tag, "_reg"},    i2c.i2c_reg, 0);
    check({tag, "_wdata"},  i2c.i2c_wdata, 0);
    check({tag, "_nbytes"}, i2c.i2c_nbytes, 0);
    check({tag, "_busy"},   O_BUSY, 0);
    check({tag, "_done"},   O_DONE, 0);
    check({tag, "_err"},    O_ERR, 0);
  endtask

  // Runs one command, acting as ROM and I2C master; cycle 1 is the cycle
  // after the start edge. abort_at >= 0 asserts reset in that cycle.
  task automatic run_cmd(input logic [3:0] addr, input int ack_dly, input bit nw, input bit nr,
                         input bit bad, input bit extra, input int abort_at);
    int   cyc, req_run, done_cnt, done_cyc, first_req, wr_done, rd_req;
    bit   done_seen, busy_ok, addr_ok, hold_bad, stable_bad, cur_rw;
    logic [1:0] got_err;
    txn_t cur;
    expect_cmd(rom[addr], nw, nr);
    if (bad) begin exp_q.delete(); exp_err = 3; exp_wait = 0; end
    got_q.delete();
    cyc = 0; req_run = 0; done_cnt = 0; done_cyc = -1; first_req = -1;
    wr_done = -1; rd_req = -1; done_seen = 0; busy_ok = 1; addr_ok = 1;
    hold_bad = 0; stable_bad = 0; cur_rw = 0; got_err = 0; cur = '{0, 0, 0, 0};

    @(negedge CLK);
    bad_echo   = bad;
    I_START    = 1'b1;
    I_CMD_ADDR = addr;
    @(negedge CLK);
    I_START = 1'b0;
    cyc = 1;
    while (!done_seen && cyc < 2000) begin
      if (cyc == abort_at) begin
        #2 RST_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        i2c.i2c_ack = 0; i2c.i2c_done = 0; i2c.i2c_nack = 0;
        @(negedge CLK);
        RST_n = 1'b1;
        return;
      end
      if (!O_BUSY) busy_ok = 0;
      if (O_ADDR_ROM != addr) addr_ok = 0;
      i2c.i2c_ack = 0; i2c.i2c_done = 0; i2c.i2c_nack = 0;
      I_START = (extra && cyc == 2);
      I_CMD_ADDR = ~addr;
      if (O_DONE) begin done_seen = 1; done_cyc = cyc; got_err = O_ERR; end
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          i2c.i2c_done = 1;
          i2c.i2c_nack = cur_rw ? nr : nw;
          if (!cur_rw) wr_done = cyc;
        end
      end
      if (i2c.i2c_req) begin
        if (req_run == 0) begin
          cur = '{i2c.i2c_rw, i2c.i2c_reg, i2c.i2c_wdata, int'(i2c.i2c_nbytes)};
          if (first_req < 0) first_req = cyc;
          if (cur.rw && wr_done >= 0 && rd_req < 0) rd_req = cyc;
        end else if (cur.rw != i2c.i2c_rw || cur.rg != i2c.i2c_reg ||
                     cur.wd != i2c.i2c_wdata || cur.nb != int'(i2c.i2c_nbytes)) begin
          stable_bad = 1;
        end
        req_run++;
        if (req_run == ack_dly + 1) begin
          i2c.i2c_ack = 1;
          got_q.push_back(cur);
          cur_rw = cur.rw;
          done_cnt = $urandom_range(1, 4);
        end
        if (req_run > ack_dly + 1) hold_bad = 1;
      end else begin
        if (req_run > 0 && req_run < ack_dly + 1) hold_bad = 1;
        req_run = 0;
      end
      @(negedge CLK);
      cyc++;
    end
    i2c.i2c_ack = 0; i2c.i2c_done = 0; i2c.i2c_nack = 0;
    I_START = 0;

    check("done_seen", done_seen, 1);
    check("err_code", got_err, exp_err);
    check("n_txn", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check("txn_rw", got_q[i].rw, exp_q[i].rw);
      check("txn_reg", got_q[i].rg, exp_q[i].rg);
      if (exp_q[i].rw) check("txn_nbytes", got_q[i].nb, exp_q[i].nb);
      else             check("txn_wdata", got_q[i].wd, exp_q[i].wd);
    end
    if (exp_q.size() > 0) check("req_latency", first_req, 3);
    else                  check("done_latency", done_cyc, 3);
    if (exp_q.size() == 2) check("conv_len", rd_req - wr_done, exp_wait + 1);
    check("busy_held", busy_ok, 1);
    check("addr_held", addr_ok, 1);
    check("req_hold", hold_bad, 0);
    check("fields_stable", stable_bad, 0);
    check("busy_fall", O_BUSY, 0);
    check("done_pulse", O_DONE, 0);
    check("err_hold", O_ERR, exp_err);
    bad_echo = 0;
    repeat (2) @(negedge CLK);
    check("idle_no_req", i2c.i2c_req, 0);
  endtask

  initial begin
    automatic logic [7:0] pool [11] = '{8'hAA, 8'hD0, 8'hB6, 8'h2E, 8'h34, 8'h74,
                                        8'hB4, 8'hF4, 8'h5A, 8'h00, 8'hFF};
    for (int i = 0; i < 16; i++) rom[i] = pool[$urandom_range(0, 10)];
    rom[0] = 8'hAA; rom[2] = 8'h2E; rom[5] = 8'h34;
    rom[6] = 8'hF4; rom[7] = 8'hB6; rom[9] = 8'h5A;
    i2c.i2c_ack = 0; i2c.i2c_done = 0; i2c.i2c_nack = 0;

    #1 check_reset_outputs("reset");
    repeat (2) @(negedge CLK);
    RST_n = 1'b1;

    run_cmd(4'd2, 0, 0, 0, 0, 0, -1);   // temperature
    run_cmd(4'd6, 1, 0, 0, 0, 0, -1);   // pressure OSS3
    run_cmd(4'd0, 5, 0, 0, 0, 0, -1);   // calibration, slow ack
    run_cmd(4'd9, 0, 0, 0, 0, 0, -1);   // unknown byte
    run_cmd(4'd7, 0, 0, 0, 0, 0, -1);   // soft reset
    run_cmd(4'd5, 0, 1, 0, 0, 1, -1);   // NACK on write, start while busy
    run_cmd(4'd3, 0, 0, 0, 1, 0, -1);   // ROM address mismatch
    run_cmd(4'd6, 0, 0, 0, 0, 0, 50);   // reset during conversion
    run_cmd(4'd2, 2, 0, 0, 0, 0, -1);   // normal after reset

    for (int k = 0; k < 16; k++) begin
      run_cmd(4'($urandom_range(0, 15)), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
